vga_text_ctrl: RTL and testbench

Parametrised character-mode VGA timing and pixel pipeline for the NPC display path. It generates sync and blanking signals for any raster geometry and produces per-character-cell addresses without dividers: text column/row plus the in-glyph pixel offset. It accepts glyph-bit and colour data returned by an external text-RAM/font-ROM path of configurable latency and drives 24-bit RGB. It adds per-cell colour and a hardware blinking cursor.

---
 rtl/vga_text_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_vga_text_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : vga_text_ctrl
// Brief   : Character-mode VGA timing generator with cell addressing, per-cell
//           colour, delayed-data pixel pipeline and a blinking cursor.
// Revision: 1.0 - initial release
// ============================================================================
module vga_text_ctrl #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter bit SYNC_POL     = 1'b0,
    parameter int CHAR_W       = 9,
    parameter int CHAR_H       = 16,
    parameter int COLS         = 71,
    parameter int ROWS         = 30,
    parameter int PIPE         = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        pclk,
    input  logic        reset,
    output logic [10:0] h_addr,
    output logic [10:0] v_addr,
    output logic [6:0]  char_col,
    output logic [5:0]  char_row,
    output logic [3:0]  glyph_x,
    output logic [4:0]  glyph_y,
    output logic        addr_valid,
    output logic        frame_start,
    input  logic [6:0]  cursor_col,
    input  logic [5:0]  cursor_row,
    input  logic        cursor_en,
    input  logic        pixel_on,
    input  logic [23:0] fg_color,
    input  logic [23:0] bg_color,
    output logic        hsync,
    output logic        vsync,
    output logic        valid,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hw      = $clog2(c_h_total + 1);
    localparam int c_vw      = $clog2(c_v_total + 1);
    localparam int c_bw      = $clog2(BLINK_FRAMES + 1);

    localparam logic [c_hw-1:0] c_h_last  = c_hw'(c_h_total - 1);
    localparam logic [c_hw-1:0] c_h_act   = c_hw'(H_ACTIVE);
    localparam logic [c_hw-1:0] c_hs_beg  = c_hw'(H_ACTIVE + H_FP);
    localparam logic [c_hw-1:0] c_hs_end  = c_hw'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_vw-1:0] c_v_last  = c_vw'(c_v_total - 1);
    localparam logic [c_vw-1:0] c_v_act   = c_vw'(V_ACTIVE);
    localparam logic [c_vw-1:0] c_vs_beg  = c_vw'(V_ACTIVE + V_FP);
    localparam logic [c_vw-1:0] c_vs_end  = c_vw'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]      c_gx_last = 4'(CHAR_W - 1);
    localparam logic [4:0]      c_gy_last = 5'(CHAR_H - 1);
    localparam logic [7:0]      c_cols    = 8'(COLS);
    localparam logic [6:0]      c_rows    = 7'(ROWS);
    localparam logic [c_bw-1:0] c_b_last  = c_bw'(BLINK_FRAMES - 1);

    logic [c_hw-1:0] r_h_cnt;
    logic [c_vw-1:0] r_v_cnt;
    logic [3:0]      r_glyph_x;
    logic [4:0]      r_glyph_y;
    logic [6:0]      r_char_col;
    logic [5:0]      r_char_row;
    logic [6:0]      r_cur_col;
    logic [5:0]      r_cur_row;
    logic            r_cur_en;
    logic [c_bw-1:0] r_blink_cnt;
    logic            r_blink_phase;
    // Pipeline word: {valid, addr_valid, hsync_act, vsync_act, cursor_hit}
    logic [4:0]      r_pipe [PIPE];

    logic w_h_wrap, w_f_wrap, w_active, w_hs_act, w_vs_act, w_hit, w_sel;
    logic [4:0]  w_d;
    logic [23:0] w_rgb;

    assign w_h_wrap = (r_h_cnt == c_h_last);
    assign w_f_wrap = w_h_wrap && (r_v_cnt == c_v_last);
    assign w_active = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
    assign w_hs_act = (r_h_cnt >= c_hs_beg) && (r_h_cnt < c_hs_end);
    assign w_vs_act = (r_v_cnt >= c_vs_beg) && (r_v_cnt < c_vs_end);

    assign h_addr      = w_active ? 11'(r_h_cnt) : 11'd0;
    assign v_addr      = w_active ? 11'(r_v_cnt) : 11'd0;
    assign char_col    = r_char_col;
    assign char_row    = r_char_row;
    assign glyph_x     = r_glyph_x;
    assign glyph_y     = r_glyph_y;
    assign addr_valid  = w_active && ({1'b0, r_char_col} < c_cols) && ({1'b0, r_char_row} < c_rows);
    assign frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

    // Range check keeps a cursor parked off-grid from matching blanking cells
    assign w_hit = r_cur_en && (r_char_col == r_cur_col) && (r_char_row == r_cur_row)
                   && ({1'b0, r_cur_col} < c_cols) && ({1'b0, r_cur_row} < c_rows);

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_h_cnt    <= '0;
            r_v_cnt    <= '0;
            r_glyph_x  <= '0;
            r_glyph_y  <= '0;
            r_char_col <= '0;
            r_char_row <= '0;
        end else begin
            r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
            if (w_h_wrap) begin
                r_glyph_x  <= '0;
                r_char_col <= '0;
            end else if (r_glyph_x == c_gx_last) begin
                r_glyph_x  <= '0;
                r_char_col <= r_char_col + 1'b1;
            end else begin
                r_glyph_x  <= r_glyph_x + 1'b1;
            end
            if (w_f_wrap) begin
                r_v_cnt    <= '0;
                r_glyph_y  <= '0;
                r_char_row <= '0;
            end else if (w_h_wrap) begin
                r_v_cnt <= r_v_cnt + 1'b1;
                if (r_glyph_y == c_gy_last) begin
                    r_glyph_y  <= '0;
                    r_char_row <= r_char_row + 1'b1;
                end else begin
                    r_glyph_y  <= r_glyph_y + 1'b1;
                end
            end
        end
    end

    // Cursor shadow and blink both update on the last pixel of the frame
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_cur_col     <= '0;
            r_cur_row     <= '0;
            r_cur_en      <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_f_wrap) begin
            r_cur_col <= cursor_col;
            r_cur_row <= cursor_row;
            r_cur_en  <= cursor_en;
            if (r_blink_cnt == c_b_last) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= {w_active, addr_valid, w_hs_act, w_vs_act, w_hit};
            for (int i = 1; i < PIPE; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_d   = r_pipe[PIPE-1];
    assign w_sel = pixel_on ^ (w_d[0] & r_blink_phase);
    assign w_rgb = w_d[3] ? (w_sel ? fg_color : bg_color) : 24'h0;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            valid <= 1'b0;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else begin
            hsync <= w_d[2] ? SYNC_POL : ~SYNC_POL;
            vsync <= w_d[1] ? SYNC_POL : ~SYNC_POL;
            valid <= w_d[4];
            vga_r <= w_rgb[23:16];
            vga_g <= w_rgb[15:8];
            vga_b <= w_rgb[7:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_text_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_text_ctrl
// Brief   : Directed self-checking bench: default timing, cursor blink on a
//           reduced raster, and a tiny active-high-sync geometry.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_text_ctrl;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- default instance ----------------
    logic        a_reset = 1'b1;
    logic [10:0] a_h_addr, a_v_addr;
    logic [6:0]  a_char_col;
    logic [5:0]  a_char_row;
    logic [3:0]  a_glyph_x;
    logic [4:0]  a_glyph_y;
    logic        a_addr_valid, a_frame_start, a_hsync, a_vsync, a_valid;
    logic [7:0]  a_r, a_g, a_b;
    logic        a_pixel_on = 1'b0;
    logic [23:0] a_rgb;
    assign a_rgb = {a_r, a_g, a_b};

    vga_text_ctrl u_def (
        .pclk(pclk), .reset(a_reset),
        .h_addr(a_h_addr), .v_addr(a_v_addr),
        .char_col(a_char_col), .char_row(a_char_row),
        .glyph_x(a_glyph_x), .glyph_y(a_glyph_y),
        .addr_valid(a_addr_valid), .frame_start(a_frame_start),
        .cursor_col(7'd0), .cursor_row(6'd0), .cursor_en(1'b0),
        .pixel_on(a_pixel_on), .fg_color(24'h123456), .bg_color(24'hABCDEF),
        .hsync(a_hsync), .vsync(a_vsync), .valid(a_valid),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b)
    );

    // ---------------- cursor instance (60x99 raster, 6x6 cells) ----------------
    logic        c_reset = 1'b1;
    logic [10:0] c_h_addr, c_v_addr;
    logic [6:0]  c_char_col;
    logic [5:0]  c_char_row;
    logic [3:0]  c_glyph_x;
    logic [4:0]  c_glyph_y;
    logic        c_addr_valid, c_frame_start, c_hsync, c_vsync, c_valid;
    logic [7:0]  c_r, c_g, c_b;
    logic [6:0]  c_cur_col = 7'd3;
    logic [5:0]  c_cur_row = 6'd2;
    logic [23:0] c_rgb;
    assign c_rgb = {c_r, c_g, c_b};

    vga_text_ctrl #(
        .H_ACTIVE(54), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(96), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .CHAR_W(9), .CHAR_H(16), .COLS(6), .ROWS(6),
        .PIPE(2), .BLINK_FRAMES(2)
    ) u_cur (
        .pclk(pclk), .reset(c_reset),
        .h_addr(c_h_addr), .v_addr(c_v_addr),
        .char_col(c_char_col), .char_row(c_char_row),
        .glyph_x(c_glyph_x), .glyph_y(c_glyph_y),
        .addr_valid(c_addr_valid), .frame_start(c_frame_start),
        .cursor_col(c_cur_col), .cursor_row(c_cur_row), .cursor_en(1'b1),
        .pixel_on(1'b0), .fg_color(24'h123456), .bg_color(24'hABCDEF),
        .hsync(c_hsync), .vsync(c_vsync), .valid(c_valid),
        .vga_r(c_r), .vga_g(c_g), .vga_b(c_b)
    );

    // ---------------- small instance (12x7 raster, 3x2 cells) ----------------
    logic        s_reset = 1'b1;
    logic [10:0] s_h_addr, s_v_addr;
    logic [6:0]  s_char_col;
    logic [5:0]  s_char_row;
    logic [3:0]  s_glyph_x;
    logic [4:0]  s_glyph_y;
    logic        s_addr_valid, s_frame_start, s_hsync, s_vsync, s_valid;
    logic [7:0]  s_r, s_g, s_b;
    logic [23:0] s_rgb;
    assign s_rgb = {s_r, s_g, s_b};

    vga_text_ctrl #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .CHAR_W(3), .CHAR_H(2), .COLS(2), .ROWS(2),
        .PIPE(1), .BLINK_FRAMES(1)
    ) u_small (
        .pclk(pclk), .reset(s_reset),
        .h_addr(s_h_addr), .v_addr(s_v_addr),
        .char_col(s_char_col), .char_row(s_char_row),
        .glyph_x(s_glyph_x), .glyph_y(s_glyph_y),
        .addr_valid(s_addr_valid), .frame_start(s_frame_start),
        .cursor_col(7'd0), .cursor_row(6'd0), .cursor_en(1'b1),
        .pixel_on(1'b1), .fg_color(24'h102030), .bg_color(24'h405060),
        .hsync(s_hsync), .vsync(s_vsync), .valid(s_valid),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
    );

    // ------------------------------------------------------------------------
    task automatic test_reset;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        n_vec++;
        if ({a_hsync, a_vsync, a_valid, a_rgb} !== {1'b1, 1'b1, 1'b0, 24'h0}) begin
            n_err++;
            $display("FAIL reset_outputs: got hs=%b vs=%b valid=%b rgb=%h, want hs=1 vs=1 valid=0 rgb=000000",
                     a_hsync, a_vsync, a_valid, a_rgb);
        end
        n_vec++;
        if ({a_frame_start, a_h_addr, a_char_col, a_glyph_x} !== {1'b1, 11'd0, 7'd0, 4'd0}) begin
            n_err++;
            $display("FAIL reset_counters: got fs=%b h=%0d col=%0d gx=%0d, want fs=1 h=0 col=0 gx=0",
                     a_frame_start, a_h_addr, a_char_col, a_glyph_x);
        end
        @(posedge pclk);
        #1 a_reset = 1'b0;
    endtask

    // Line 0 of the default raster: sync/valid windows, colour latency, cells.
    task automatic test_line0;
        logic        exp_hs, exp_valid;
        logic [23:0] exp_rgb;
        logic [10:0] exp_h;
        for (int n = 0; n < 800; n++) begin
            a_pixel_on = (n == 22);
            @(negedge pclk);
            exp_hs    = !(n >= 659 && n <= 754);
            exp_valid = (n >= 3 && n <= 642);
            exp_rgb   = (n >= 3 && n <= 641) ? ((n == 23) ? 24'h123456 : 24'hABCDEF) : 24'h0;
            exp_h     = (n < 640) ? 11'(n) : 11'd0;
            n_vec++;
            if ({a_hsync, a_vsync, a_valid} !== {exp_hs, 1'b1, exp_valid}) begin
                n_err++;
                $display("FAIL line0_sync n=%0d: got hs=%b vs=%b valid=%b, want hs=%b vs=1 valid=%b",
                         n, a_hsync, a_vsync, a_valid, exp_hs, exp_valid);
            end
            n_vec++;
            if (a_rgb !== exp_rgb) begin
                n_err++;
                $display("FAIL line0_rgb n=%0d: got %h want %h", n, a_rgb, exp_rgb);
            end
            n_vec++;
            if (a_h_addr !== exp_h) begin
                n_err++;
                $display("FAIL line0_haddr n=%0d: got %0d want %0d", n, a_h_addr, exp_h);
            end
            if (n == 8 || n == 9 || n == 639) begin
                n_vec++;
                if ({a_char_col, a_glyph_x, a_addr_valid} !==
                    {(n == 8) ? 7'd0 : (n == 9) ? 7'd1 : 7'd71, (n == 8) ? 4'd8 : 4'd0, n != 639}) begin
                    n_err++;
                    $display("FAIL line0_cell n=%0d: got col=%0d gx=%0d av=%b", n, a_char_col, a_glyph_x, a_addr_valid);
                end
            end
            @(posedge pclk);
            #1;
        end
        a_pixel_on = 1'b0;
    endtask

    task automatic test_rows;
        repeat (11999) @(posedge pclk);
        @(negedge pclk);
        n_vec++;
        if ({a_char_row, a_glyph_y, a_addr_valid} !== {6'd0, 5'd15, 1'b0}) begin
            n_err++;
            $display("FAIL row_v15_end: got row=%0d gy=%0d av=%b, want row=0 gy=15 av=0", a_char_row, a_glyph_y, a_addr_valid);
        end
        @(posedge pclk);
        @(negedge pclk);
        n_vec++;
        if ({a_v_addr, a_char_row, a_glyph_y, a_addr_valid, a_frame_start} !== {11'd16, 6'd1, 5'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL row_v16: got v=%0d row=%0d gy=%0d av=%b fs=%b, want v=16 row=1 gy=0 av=1 fs=0",
                     a_v_addr, a_char_row, a_glyph_y, a_addr_valid, a_frame_start);
        end
    endtask

    function automatic logic [23:0] cur_expect(int k);
        int f, h, v, cc, cr;
        logic on_cursor, phase;
        f = k / 5940;
        h = k % 60;
        v = (k % 5940) / 60;
        if (h >= 54 || v >= 96) return 24'h0;
        if (f == 0)      begin cc = -1; cr = -1; end
        else if (f <= 2) begin cc = 3;  cr = 2;  end
        else             begin cc = 5;  cr = 5;  end
        phase     = ((f / 2) % 2) == 1;
        on_cursor = (h / 9 == cc) && (v / 16 == cr);
        return (on_cursor && phase) ? 24'h123456 : 24'hABCDEF;
    endfunction

    // Blink with BLINK_FRAMES=2 and a cursor moved mid-frame 2.
    task automatic test_cursor_blink;
        logic [23:0] exp_rgb;
        @(posedge pclk);
        #1 c_reset = 1'b0;
        for (int n = 0; n <= 4 * 5940 + 3; n++) begin
            if (n == 2 * 5940 + 3000) begin
                c_cur_col = 7'd5;
                c_cur_row = 6'd5;
            end
            @(negedge pclk);
            exp_rgb = (n >= 3) ? cur_expect(n - 3) : 24'h0;
            n_vec++;
            if (c_rgb !== exp_rgb) begin
                n_err++;
                $display("FAIL cursor_rgb n=%0d: got %h want %h", n, c_rgb, exp_rgb);
            end
            if (n == 96 * 60) begin
                n_vec++;
                if ({c_addr_valid, c_char_row, c_v_addr} !== {1'b0, 6'd6, 11'd0}) begin
                    n_err++;
                    $display("FAIL cursor_bottom_edge: got av=%b row=%0d v=%0d, want av=0 row=6 v=0",
                             c_addr_valid, c_char_row, c_v_addr);
                end
            end
            @(posedge pclk);
            #1;
        end
    endtask

    // Tiny geometry with active-high syncs, PIPE=1, blink every frame.
    task automatic test_small_geometry;
        int h, v, k, kh, kv, f;
        logic [23:0] exp_rgb;
        logic        exp_hs, exp_vs, exp_valid, av, sel;
        @(posedge pclk);
        #1 s_reset = 1'b0;
        for (int n = 0; n < 3 * 84; n++) begin
            @(negedge pclk);
            h = n % 12;
            v = (n / 12) % 7;
            n_vec++;
            if ({s_char_col, s_glyph_x, s_char_row, s_glyph_y, s_addr_valid, s_frame_start} !==
                {7'(h / 3), 4'(h % 3), 6'(v / 2), 5'(v % 2), (h < 6 && v < 4), (n % 84 == 0)}) begin
                n_err++;
                $display("FAIL small_cells n=%0d: got col=%0d gx=%0d row=%0d gy=%0d av=%b fs=%b (h=%0d v=%0d)",
                         n, s_char_col, s_glyph_x, s_char_row, s_glyph_y, s_addr_valid, s_frame_start, h, v);
            end
            exp_hs = 1'b0; exp_vs = 1'b0; exp_valid = 1'b0; exp_rgb = 24'h0;
            if (n >= 2) begin
                k  = n - 2;
                kh = k % 12;
                kv = (k / 12) % 7;
                f  = k / 84;
                exp_hs    = (kh == 9 || kh == 10);
                exp_vs    = (kv == 5);
                exp_valid = (kh < 8 && kv < 4);
                av        = (kh < 6 && kv < 4);
                sel       = 1'b1 ^ ((f >= 1) && kh < 3 && kv < 2 && (f % 2 == 1));
                exp_rgb   = av ? (sel ? 24'h102030 : 24'h405060) : 24'h0;
            end
            n_vec++;
            if ({s_hsync, s_vsync, s_valid, s_rgb} !== {exp_hs, exp_vs, exp_valid, exp_rgb}) begin
                n_err++;
                $display("FAIL small_out n=%0d: got hs=%b vs=%b valid=%b rgb=%h, want hs=%b vs=%b valid=%b rgb=%h",
                         n, s_hsync, s_vsync, s_valid, s_rgb, exp_hs, exp_vs, exp_valid, exp_rgb);
            end
            @(posedge pclk);
            #1;
        end
    endtask

    // Reset applied between clock edges must clear outputs immediately.
    task automatic test_async_reset;
        repeat (5) @(posedge pclk);
        @(negedge pclk);
        n_vec++;
        if ({s_valid, s_rgb} !== {1'b1, 24'h102030}) begin
            n_err++;
            $display("FAIL async_pre: got valid=%b rgb=%h, want valid=1 rgb=102030", s_valid, s_rgb);
        end
        #1 s_reset = 1'b1;
        #1;
        n_vec++;
        if ({s_valid, s_rgb, s_hsync, s_vsync} !== {1'b0, 24'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL async_outputs: got valid=%b rgb=%h hs=%b vs=%b, want 0/000000/0/0",
                     s_valid, s_rgb, s_hsync, s_vsync);
        end
        n_vec++;
        if ({s_char_col, s_glyph_x, s_frame_start} !== {7'd0, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL async_counters: got col=%0d gx=%0d fs=%b, want 0/0/1", s_char_col, s_glyph_x, s_frame_start);
        end
    endtask

    initial begin
        test_reset();
        test_line0();
        test_rows();
        test_cursor_blink();
        test_small_geometry();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
